// File: rtl/fetch_stage_if.sv
// Instruction-memory port of the fetch stage.
// Handshake: a request transfers in a cycle where imem_req_valid and
// imem_req_ready are both high; the memory returns exactly one
// imem_resp_valid pulse (with imem_resp_data) per transferred request, at
// the earliest in the following cycle. imem_req_addr is meaningful only
// while imem_req_valid is high. Reset drops any request in flight.
interface fetch_stage_if;
    logic [31:0] imem_req_addr;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_resp_data;
    logic        imem_resp_valid;

    modport master (
        output imem_req_addr,
        output imem_req_valid,
        input  imem_req_ready,
        input  imem_resp_data,
        input  imem_resp_valid
    );

    modport slave (
        input  imem_req_addr,
        input  imem_req_valid,
        output imem_req_ready,
        output imem_resp_data,
        output imem_resp_valid
    );
endinterface

// File: rtl/fetch_stage.sv
// First pipeline stage: owns the PC, keeps at most one instruction-memory
// read in flight and hands {pc, instruction} to decode. Decode takes the
// held instruction in a cycle where done_next is high and next_stall is low.
// A redirect (control_flow_affected && jump_target_valid) reloads the PC,
// empties the output register and discards any wrong-path response.
module fetch_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    localparam int ADDR_WIDTH        = 32,
    localparam int INSTRUCTION_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         next_stall,
    output logic                         done_next,
    input  logic                         control_flow_affected,
    input  logic [ADDR_WIDTH-1:0]        jump_target,
    input  logic                         jump_target_valid,
    fetch_stage_if.master                imem,
    output logic [ADDR_WIDTH-1:0]        program_count_out,
    output logic                         program_count_valid_out,
    output logic [INSTRUCTION_WIDTH-1:0] instruction_data_out,
    output logic                         instruction_data_valid_out,
    output logic [1:0]                   state_dbg
);

    typedef enum logic [1:0] {
        S_REQ    = 2'd0,
        S_WAIT   = 2'd1,
        S_SQUASH = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t                       state, state_nx;
    logic [ADDR_WIDTH-1:0]        pc, pc_nx;
    logic                         done_nx;
    logic [ADDR_WIDTH-1:0]        pc_out_nx;
    logic                         pc_valid_nx;
    logic [INSTRUCTION_WIDTH-1:0] instr_nx;
    logic                         instr_valid_nx;
    logic                         req_valid;

    logic redirect;
    logic transfer;
    logic misaligned;

    assign redirect   = control_flow_affected && jump_target_valid;
    assign transfer   = done_next && !next_stall;
    assign misaligned = (pc[1:0] != 2'b00);
    assign state_dbg  = state;

    // Next-state, next-PC, next output register and memory request.
    always_comb begin
        state_nx       = state;
        pc_nx          = pc;
        done_nx        = done_next;
        pc_out_nx      = program_count_out;
        pc_valid_nx    = program_count_valid_out;
        instr_nx       = instruction_data_out;
        instr_valid_nx = instruction_data_valid_out;
        req_valid      = 1'b0;

        case (state)
            S_REQ: begin
                if (misaligned) begin
                    // Misaligned PC: no read, deliver a marker carrying the PC only.
                    // The PC stays put; decode is expected to redirect.
                    state_nx       = S_HOLD;
                    done_nx        = 1'b1;
                    pc_out_nx      = pc;
                    pc_valid_nx    = 1'b1;
                    instr_nx       = '0;
                    instr_valid_nx = 1'b0;
                end else begin
                    req_valid = 1'b1;
                    if (imem.imem_req_ready) begin
                        state_nx = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (imem.imem_resp_valid) begin
                    state_nx       = S_HOLD;
                    done_nx        = 1'b1;
                    pc_out_nx      = pc;
                    pc_valid_nx    = 1'b1;
                    instr_nx       = imem.imem_resp_data;
                    instr_valid_nx = 1'b1;
                    pc_nx          = pc + ADDR_WIDTH'(4);
                end
            end
            S_SQUASH: begin
                if (imem.imem_resp_valid) begin
                    state_nx = S_REQ;
                end
            end
            S_HOLD: begin
                if (transfer) begin
                    state_nx       = S_REQ;
                    done_nx        = 1'b0;
                    pc_out_nx      = '0;
                    pc_valid_nx    = 1'b0;
                    instr_nx       = '0;
                    instr_valid_nx = 1'b0;
                end
            end
            default: begin
                state_nx = S_REQ;
            end
        endcase

        // Redirect overrides everything above; the only question is whether a
        // wrong-path response is still owed by the memory.
        if (redirect) begin
            pc_nx          = jump_target;
            done_nx        = 1'b0;
            pc_out_nx      = '0;
            pc_valid_nx    = 1'b0;
            instr_nx       = '0;
            instr_valid_nx = 1'b0;
            case (state)
                S_REQ:    state_nx = (req_valid && imem.imem_req_ready) ? S_SQUASH : S_REQ;
                S_WAIT:   state_nx = imem.imem_resp_valid ? S_REQ : S_SQUASH;
                // A response landing in the redirect cycle settles the debt;
                // waiting for another one would never end.
                S_SQUASH: state_nx = imem.imem_resp_valid ? S_REQ : S_SQUASH;
                default:  state_nx = S_REQ;
            endcase
        end

        imem.imem_req_valid = req_valid && !rst;
        imem.imem_req_addr  = pc;
    end

    // State, PC and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                      <= S_REQ;
            pc                         <= RESET_VECTOR;
            done_next                  <= 1'b0;
            program_count_out          <= '0;
            program_count_valid_out    <= 1'b0;
            instruction_data_out       <= '0;
            instruction_data_valid_out <= 1'b0;
        end else begin
            state                      <= state_nx;
            pc                         <= pc_nx;
            done_next                  <= done_nx;
            program_count_out          <= pc_out_nx;
            program_count_valid_out    <= pc_valid_nx;
            instruction_data_out       <= instr_nx;
            instruction_data_valid_out <= instr_valid_nx;
        end
    end

    // A response is only legal while one is owed.
    a_no_stray_resp: assert property (@(posedge clk) disable iff (rst)
        !(imem.imem_resp_valid && (state == S_REQ || state == S_HOLD)));

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a cycle table for in-order fetch, stall, ready
// back-pressure and the misaligned marker, then hand sequences for the
// redirect/squash and mid-flight reset cases. Memory word at address a is
// 32'hC0DE_0000 ^ a.
module tb_fetch_stage;

    localparam logic [31:0] W = 32'hC0DE_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        next_stall;
    logic        done_next;
    logic        control_flow_affected;
    logic [31:0] jump_target;
    logic        jump_target_valid;
    logic [31:0] program_count_out;
    logic        program_count_valid_out;
    logic [31:0] instruction_data_out;
    logic        instruction_data_valid_out;
    logic [1:0]  state_dbg;

    fetch_stage_if bus ();

    fetch_stage #(.RESET_VECTOR(32'h0000_0000)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .next_stall                 (next_stall),
        .done_next                  (done_next),
        .control_flow_affected      (control_flow_affected),
        .jump_target                (jump_target),
        .jump_target_valid          (jump_target_valid),
        .imem                       (bus),
        .program_count_out          (program_count_out),
        .program_count_valid_out    (program_count_valid_out),
        .instruction_data_out       (instruction_data_out),
        .instruction_data_valid_out (instruction_data_valid_out),
        .state_dbg                  (state_dbg)
    );

    // Clock.
    always #5 clk = ~clk;

    // Watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int n_vec  = 0;
    int n_miss = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Memory model: samples the request mid-cycle, answers mem_lat cycles
    // after acceptance, forgets a pending read on reset.
    int          mem_lat = 1;
    int          mem_cnt;
    logic        mem_pend;
    logic [31:0] mem_pend_addr;
    logic        mem_acc;
    logic [31:0] mem_addr_s;
    logic        mem_rst_s;

    initial begin
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        mem_pend = 1'b0;
        mem_cnt  = 0;
        forever begin
            @(negedge clk);
            mem_acc    = bus.imem_req_valid && bus.imem_req_ready;
            mem_addr_s = bus.imem_req_addr;
            mem_rst_s  = rst;
            @(posedge clk);
            #1;
            bus.imem_resp_valid = 1'b0;
            if (mem_rst_s) begin
                mem_pend = 1'b0;
            end else begin
                if (mem_acc) begin
                    mem_pend      = 1'b1;
                    mem_pend_addr = mem_addr_s;
                    mem_cnt       = mem_lat;
                end
                if (mem_pend) begin
                    mem_cnt--;
                    if (mem_cnt == 0) begin
                        bus.imem_resp_valid = 1'b1;
                        bus.imem_resp_data  = W ^ mem_pend_addr;
                        mem_pend = 1'b0;
                    end
                end
            end
        end
    end

    typedef struct {
        logic        rst;
        logic        stall;
        logic        cfa;
        logic        jtv;
        logic [31:0] jt;
        logic        ready;
        logic        req_v;
        logic [31:0] addr;
        logic        done;
        logic [31:0] pc_o;
        logic        pcv;
        logic        iv;
        logic [31:0] instr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic s, logic c, logic v, logic [31:0] t, logic rd,
                                logic qv, logic [31:0] a, logic d, logic [31:0] po,
                                logic pv, logic iv, logic [31:0] ins);
        vec_t x;
        x.rst = r; x.stall = s; x.cfa = c; x.jtv = v; x.jt = t; x.ready = rd;
        x.req_v = qv; x.addr = a; x.done = d; x.pc_o = po; x.pcv = pv; x.iv = iv; x.instr = ins;
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        next_stall = 1'b0;
        control_flow_affected = 1'b0;
        jump_target_valid = 1'b0;
        jump_target = '0;
        bus.imem_req_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Waits (bounded) for the next delivered instruction, checks it, lets decode take it.
    task automatic expect_delivery(input string name, input logic [31:0] exp_pc,
                                   input logic [31:0] exp_instr, input logic exp_iv);
        int  n = 0;
        bit  seen = 0;
        while (n < 20 && !seen) begin
            @(negedge clk);
            if (done_next) seen = 1;
            else begin
                tick();
                n++;
            end
        end
        if (!seen) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s timeout: no done_next within 20 cycles, expected pc %h", name, exp_pc);
        end else begin
            check({name, " pc"}, program_count_out, exp_pc);
            check({name, " pc_valid"}, 32'(program_count_valid_out), 32'd1);
            check({name, " instr"}, instruction_data_out, exp_instr);
            check({name, " instr_valid"}, 32'(instruction_data_valid_out), 32'(exp_iv));
            tick();
        end
    endtask

    initial begin
        // Table: reset, fetch 0/4/8, 5-cycle stall, fetch C, ready low, misaligned marker, jtv=0.
        vecs.push_back(mk(1,0,0,0,0,1, 0,32'h0, 0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,1, 1,32'h0, 0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,1, 0,32'h0, 0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,1, 0,32'h4, 1,32'h0,1,1,W|32'h0));
        vecs.push_back(mk(0,0,0,0,0,1, 1,32'h4, 0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,1, 0,32'h4, 0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,1, 0,32'h8, 1,32'h4,1,1,W|32'h4));
        vecs.push_back(mk(0,0,0,0,0,1, 1,32'h8, 0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,1, 0,32'h8, 0,0,0,0,0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0,1,0,0,0,1, 0,32'hC, 1,32'h8,1,1,W|32'h8));
        vecs.push_back(mk(0,0,0,0,0,1, 0,32'hC, 1,32'h8,1,1,W|32'h8));
        vecs.push_back(mk(0,0,0,0,0,1, 1,32'hC, 0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,1, 0,32'hC, 0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,1, 0,32'h10, 1,32'hC,1,1,W|32'hC));
        vecs.push_back(mk(0,0,0,0,0,0, 1,32'h10, 0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,1, 1,32'h10, 0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,1, 0,32'h10, 0,0,0,0,0));
        vecs.push_back(mk(0,0,1,1,32'h102,1, 0,32'h14, 1,32'h10,1,1,W|32'h10));
        vecs.push_back(mk(0,0,0,0,0,1, 0,32'h102, 0,0,0,0,0));
        vecs.push_back(mk(0,0,1,1,32'h20,1, 0,32'h102, 1,32'h102,1,0,32'h0));
        vecs.push_back(mk(0,0,0,0,0,1, 1,32'h20, 0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,1, 0,32'h20, 0,0,0,0,0));
        vecs.push_back(mk(0,0,1,0,32'h300,1, 0,32'h24, 1,32'h20,1,1,W|32'h20));
        vecs.push_back(mk(0,0,0,0,0,0, 1,32'h24, 0,0,0,0,0));

        rst = 1'b1;
        next_stall = 1'b0;
        control_flow_affected = 1'b0;
        jump_target_valid = 1'b0;
        jump_target = '0;
        bus.imem_req_ready = 1'b0;
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            rst                   = vecs[i].rst;
            next_stall            = vecs[i].stall;
            control_flow_affected = vecs[i].cfa;
            jump_target_valid     = vecs[i].jtv;
            jump_target           = vecs[i].jt;
            bus.imem_req_ready    = vecs[i].ready;
            @(negedge clk);
            check($sformatf("v%0d req_valid", i), 32'(bus.imem_req_valid), 32'(vecs[i].req_v));
            check($sformatf("v%0d req_addr", i), bus.imem_req_addr, vecs[i].addr);
            check($sformatf("v%0d done_next", i), 32'(done_next), 32'(vecs[i].done));
            check($sformatf("v%0d pc_out", i), program_count_out, vecs[i].pc_o);
            check($sformatf("v%0d pc_valid", i), 32'(program_count_valid_out), 32'(vecs[i].pcv));
            check($sformatf("v%0d instr_valid", i), 32'(instruction_data_valid_out), 32'(vecs[i].iv));
            check($sformatf("v%0d instr", i), instruction_data_out, vecs[i].instr);
            tick();
        end

        // Redirect while waiting; wrong-path response arrives 3 cycles later.
        do_reset();
        mem_lat = 4;
        @(negedge clk);
        check("t3 first req_valid", 32'(bus.imem_req_valid), 32'd1);
        check("t3 first req_addr", bus.imem_req_addr, 32'h0);
        tick();
        control_flow_affected = 1'b1;
        jump_target_valid     = 1'b1;
        jump_target           = 32'h100;
        @(negedge clk);
        check("t3 wait state", 32'(state_dbg), 32'd1);
        tick();
        control_flow_affected = 1'b0;
        jump_target_valid     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("t3 squash%0d state", i), 32'(state_dbg), 32'd2);
            check($sformatf("t3 squash%0d req_valid", i), 32'(bus.imem_req_valid), 32'd0);
            check($sformatf("t3 squash%0d done_next", i), 32'(done_next), 32'd0);
            tick();
        end
        mem_lat = 1;
        @(negedge clk);
        check("t3 retarget req_valid", 32'(bus.imem_req_valid), 32'd1);
        check("t3 retarget req_addr", bus.imem_req_addr, 32'h100);
        expect_delivery("t3 deliver", 32'h100, W | 32'h100, 1'b1);

        // Redirect to 0x40 in the same cycle the read at 0x8 is accepted.
        do_reset();
        mem_lat = 1;
        begin
            int  n = 0;
            bit  found = 0;
            while (n < 20 && !found) begin
                @(negedge clk);
                if (bus.imem_req_valid && bus.imem_req_addr == 32'h8) found = 1;
                else begin
                    tick();
                    n++;
                end
            end
            if (!found) begin
                n_vec++;
                n_miss++;
                $display("FAIL t4 timeout: no request at 0x8 within 20 cycles, expected one");
            end else begin
                control_flow_affected = 1'b1;
                jump_target_valid     = 1'b1;
                jump_target           = 32'h40;
                tick();
                control_flow_affected = 1'b0;
                jump_target_valid     = 1'b0;
                @(negedge clk);
                check("t4 squash state", 32'(state_dbg), 32'd2);
                check("t4 squash req_valid", 32'(bus.imem_req_valid), 32'd0);
                exp_q.push_back(32'h40);
                exp_q.push_back(32'h44);
                while (exp_q.size() > 0) begin
                    logic [31:0] p;
                    p = exp_q.pop_front();
                    expect_delivery($sformatf("t4 deliver %h", p), p, W ^ p, 1'b1);
                end
            end
        end

        // Reset while waiting: nothing stale, fetch restarts at the reset vector.
        do_reset();
        mem_lat = 3;
        @(negedge clk);
        check("t6 first req_valid", 32'(bus.imem_req_valid), 32'd1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("t6 wait state", 32'(state_dbg), 32'd1);
        check("t6 req_valid in rst", 32'(bus.imem_req_valid), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t6 done_next", 32'(done_next), 32'd0);
        check("t6 pc_valid", 32'(program_count_valid_out), 32'd0);
        check("t6 instr_valid", 32'(instruction_data_valid_out), 32'd0);
        check("t6 state", 32'(state_dbg), 32'd0);
        check("t6 restart req_valid", 32'(bus.imem_req_valid), 32'd1);
        check("t6 restart req_addr", bus.imem_req_addr, 32'h0);
        expect_delivery("t6 deliver", 32'h0, W, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
